mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port synchronous word RAM between the CPU instruction-fetch path and the load/store data path. It is used when IMEM and DMEM are merged into one unified memory behind sccomp_dataflow. The block arbitrates each cycle and drives the RAM port. It returns a one-cycle-later ack and read data to the winning requester, and raises a stall to the CPU while any request is outstanding. Data accesses have fixed priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, byte-address width from the CPU
DATA_W, 32, data word width
MAX_STARVE, 4, consecutive cycles fetch may lose to data before it is forced to win (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  ADDR_W  fetch byte address; stable while if_req
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched instruction word
d_req  in  1  data request; held high until d_ack
d_we  in  1  1 = store, 0 = load; stable while d_req
d_addr  in  ADDR_W  data byte address; stable while d_req
d_wdata  in  DATA_W  store data; stable while d_req
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  load data, valid with d_ack
mem_en  out  1  RAM access this cycle
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W-2  RAM word address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en
cpu_stall  out  1  freeze PC/regfile write
misalign  out  1  one-cycle pulse when a granted address has addr[1:0] != 0

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: if_ack=0, d_ack=0, misalign=0, in-flight owner=NONE, starve_cnt=0. Comb outputs are then mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0. cpu_stall follows requests even during reset.
- Reset mid-operation: the in-flight access is discarded; no ack is issued in the cycle after reset deasserts.
- In-flight register: owner ∈ {NONE, IF, D}, registered. It is set to the grant winner each cycle, or NONE if there is no grant.
- Eligibility in cycle t: req=1 AND owner≠that requester. A requester being acked this cycle still shows req high and must not be re-granted.
- Grant priority:
  - Only data eligible -> D.
  - Only fetch eligible -> IF.
  - Both eligible -> D, unless starve_cnt==MAX_STARVE, then IF.
- starve_cnt update:
  - +1 (saturating) when both are eligible and D wins.
  - Cleared to 0 when IF is granted.
  - Holds otherwise.
- RAM drive (combinational in grant cycle): mem_en=1, mem_addr=addr[ADDR_W-1:2] of the winner. For a D grant, mem_we=d_we and mem_wdata=d_wdata. For an IF grant, mem_we=0 and mem_wdata=0. With no grant, all mem_* = 0.
- Ack latency: exactly 1 cycle after grant. if_ack/d_ack are registered and decoded from owner. if_rdata = mem_rdata when if_ack, else 0. d_rdata = mem_rdata when d_ack and the access was a load, else 0. The we bit is registered with owner.
- Throughput: back-to-back grants allowed, so one access per cycle when requests alternate.
- cpu_stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- misalign: registered, pulses with the ack of a granted access whose addr[1:0]≠0. The access still executes on the truncated word address.
- No ack may ever be asserted without a matching grant in the previous cycle. if_ack and d_ack are never high together.

Decomposition:
- Shared package: owner encoding (OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2); default ADDR_W/DATA_W constants.
- One sub-module, mem_arb_pick: eligibility, priority, and starve_cnt register; outputs the winner.
- Top holds the owner/we/misalign registers and the RAM/ack muxing.

Test Plan:
- Reset with if_req=1 for 3 cycles:
  - During reset: no mem_en, if_ack=0.
  - After release: mem_en the next cycle, if_ack the cycle after.
- Fetch only, if_addr=0x00400004, mem_rdata=0x2001000A: mem_addr=0x00100001; next cycle if_ack=1, if_rdata=0x2001000A; cpu_stall low in the ack cycle.
- Simultaneous if_req and d_req (load 0x10010000):
  - Cycle 0: D granted.
  - Cycle 1: d_ack, and IF granted in the same cycle (back-to-back).
  - Cycle 2: if_ack.
- Store d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF: mem_we=1, mem_addr=2, mem_wdata=0xDEADBEEF; d_ack next cycle, d_rdata=0.
- Starvation, MAX_STARVE=4: fetch and a stream of back-to-back data requests both held.
  - D wins 4 times while fetch is eligible.
  - Then IF is forced and starve_cnt returns to 0.
- Misaligned d_addr=0x6: mem_addr=1; misalign pulses with d_ack; reset asserted during the grant cycle -> no d_ack afterward.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified IMEM/DMEM port arbiter.
// Owner encoding and default bus widths.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU fetch/data request buses plus the single RAM port.
// slave = arbiter side, master = CPU/RAM side.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              cpu_stall;
   logic              misalign;

   modport slave (
      input  if_req, if_addr, d_req, d_we,
      input  d_addr, d_wdata, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output cpu_stall, misalign
   );

   modport master (
      output if_req, if_addr, d_req, d_we,
      output d_addr, d_wdata, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  cpu_stall, misalign
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Per-cycle grant selection: data has priority, fetch is
// forced through after MAX_STARVE consecutive losses.
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_STARVE = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   if_req,
   input  logic   d_req,
   input  owner_t owner,
   output owner_t win
);

   localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

   logic [3:0] starve_cnt;
   logic       if_el;
   logic       d_el;
   logic       both;

   // A requester in its ack cycle still shows req; skip it.
   always_comb begin
      if_el = ~reset & if_req & (owner != OWN_IF);
      d_el  = ~reset & d_req & (owner != OWN_D);
      both  = if_el & d_el;
      win   = OWN_NONE;
      if (both) begin
         if (starve_cnt == STARVE_LIM) win = OWN_IF;
         else                          win = OWN_D;
      end else if (d_el) begin
         win = OWN_D;
      end else if (if_el) begin
         win = OWN_IF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= 4'd0;
      end else if (win == OWN_IF) begin
         starve_cnt <= 4'd0;
      end else if (both && starve_cnt != 4'hF) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word RAM between fetch and load/store.
// Grant drives the RAM combinationally; ack follows one cycle later.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MAX_STARVE = 4
) (
   input logic             clk,
   input logic             reset,
   mem_port_arbiter_if.slave bus
);

   owner_t win;
   owner_t owner;
   logic   we_q;
   logic   mis_q;

   mem_arb_pick #(
      .MAX_STARVE (MAX_STARVE)
   ) u_pick (
      .clk    (clk),
      .reset  (reset),
      .if_req (bus.if_req),
      .d_req  (bus.d_req),
      .owner  (owner),
      .win    (win)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         owner <= OWN_NONE;
         we_q  <= 1'b0;
         mis_q <= 1'b0;
      end else begin
         owner <= win;
         we_q  <= (win == OWN_D) & bus.d_we;
         mis_q <= ((win == OWN_D) & (bus.d_addr[1:0] != 2'b00))
                | ((win == OWN_IF) & (bus.if_addr[1:0] != 2'b00));
      end
   end

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (win == OWN_D) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.d_we;
         bus.mem_addr  = bus.d_addr[ADDR_W-1:2];
         bus.mem_wdata = bus.d_wdata;
      end else if (win == OWN_IF) begin
         bus.mem_en    = 1'b1;
         bus.mem_addr  = bus.if_addr[ADDR_W-1:2];
      end
   end

   assign bus.if_ack   = (owner == OWN_IF);
   assign bus.d_ack    = (owner == OWN_D);
   assign bus.misalign = mis_q;

   assign bus.if_rdata = bus.if_ack ? bus.mem_rdata : '0;
   assign bus.d_rdata  = (bus.d_ack & ~we_q) ? bus.mem_rdata : '0;

   assign bus.cpu_stall = (bus.if_req & ~bus.if_ack)
                        | (bus.d_req & ~bus.d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter and its grant picker.
// Inputs change 1ns after posedge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   nchk = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MAX_STARVE (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic   pk_reset;
   logic   pk_if_req;
   logic   pk_d_req;
   owner_t pk_owner;
   owner_t pk_win;

   mem_arb_pick #(.MAX_STARVE(4)) u_pk (
      .clk    (clk),
      .reset  (pk_reset),
      .if_req (pk_if_req),
      .d_req  (pk_d_req),
      .owner  (pk_owner),
      .win    (pk_win)
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h0040_0004;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;
      pk_reset      = 1'b1;
      pk_if_req     = 1'b0;
      pk_d_req      = 1'b0;
      pk_owner      = OWN_NONE;

      // reset held with fetch pending
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
         chk("rst_if_ack", 64'(bus.if_ack), 64'd0);
         chk("rst_stall", 64'(bus.cpu_stall), 64'd1);
         chk("rst_addr", 64'(bus.mem_addr), 64'd0);
      end
      reset = 1'b0;
      #1;
      chk("if_mem_en", 64'(bus.mem_en), 64'd1);
      chk("if_mem_we", 64'(bus.mem_we), 64'd0);
      chk("if_mem_addr", 64'(bus.mem_addr), 64'h0010_0001);
      chk("if_ack_early", 64'(bus.if_ack), 64'd0);
      step();
      bus.mem_rdata = 32'h2001_000A;
      #1;
      chk("if_ack", 64'(bus.if_ack), 64'd1);
      chk("if_rdata", 64'(bus.if_rdata), 64'h2001_000A);
      chk("if_stall", 64'(bus.cpu_stall), 64'd0);
      chk("if_no_regrant", 64'(bus.mem_en), 64'd0);
      bus.if_req = 1'b0;
      step();
      chk("if_ack_pulse", 64'(bus.if_ack), 64'd0);
      chk("if_rdata_zero", 64'(bus.if_rdata), 64'd0);

      // simultaneous fetch + load: D first, then IF back-to-back
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0040_0008;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h1001_0000;
      #1;
      chk("sim_c0_addr", 64'(bus.mem_addr), 64'h0400_4000);
      chk("sim_c0_we", 64'(bus.mem_we), 64'd0);
      chk("sim_c0_stall", 64'(bus.cpu_stall), 64'd1);
      step();
      bus.mem_rdata = 32'h1122_3344;
      #1;
      chk("sim_c1_d_ack", 64'(bus.d_ack), 64'd1);
      chk("sim_c1_d_rdata", 64'(bus.d_rdata), 64'h1122_3344);
      chk("sim_c1_if_ack", 64'(bus.if_ack), 64'd0);
      chk("sim_c1_en", 64'(bus.mem_en), 64'd1);
      chk("sim_c1_addr", 64'(bus.mem_addr), 64'h0010_0002);
      bus.d_req = 1'b0;
      step();
      bus.mem_rdata = 32'hCAFE_F00D;
      #1;
      chk("sim_c2_if_ack", 64'(bus.if_ack), 64'd1);
      chk("sim_c2_d_ack", 64'(bus.d_ack), 64'd0);
      chk("sim_c2_rdata", 64'(bus.if_rdata), 64'hCAFE_F00D);
      chk("sim_c2_d_rdata", 64'(bus.d_rdata), 64'd0);
      bus.if_req = 1'b0;
      step();

      // store
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h0000_0008;
      bus.d_wdata = 32'hDEAD_BEEF;
      #1;
      chk("st_en", 64'(bus.mem_en), 64'd1);
      chk("st_we", 64'(bus.mem_we), 64'd1);
      chk("st_addr", 64'(bus.mem_addr), 64'd2);
      chk("st_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
      step();
      bus.mem_rdata = 32'h5555_5555;
      #1;
      chk("st_d_ack", 64'(bus.d_ack), 64'd1);
      chk("st_d_rdata", 64'(bus.d_rdata), 64'd0);
      chk("st_misalign", 64'(bus.misalign), 64'd0);
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_wdata = '0;
      step();
      chk("st_ack_pulse", 64'(bus.d_ack), 64'd0);

      // misaligned load
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h0000_0006;
      #1;
      chk("mis_addr", 64'(bus.mem_addr), 64'd1);
      step();
      chk("mis_d_ack", 64'(bus.d_ack), 64'd1);
      chk("mis_pulse", 64'(bus.misalign), 64'd1);
      bus.d_req = 1'b0;
      step();
      chk("mis_clear", 64'(bus.misalign), 64'd0);

      // reset lands on the grant cycle
      bus.d_req = 1'b1;
      reset     = 1'b1;
      #1;
      chk("rg_en", 64'(bus.mem_en), 64'd0);
      step();
      reset     = 1'b0;
      bus.d_req = 1'b0;
      #1;
      chk("rg_no_ack", 64'(bus.d_ack), 64'd0);
      chk("rg_no_mis", 64'(bus.misalign), 64'd0);
      step();
      chk("rg_no_ack2", 64'(bus.d_ack), 64'd0);

      // starvation limit on the picker with both always eligible
      pk_reset = 1'b1;
      step();
      pk_reset  = 1'b0;
      pk_if_req = 1'b1;
      pk_d_req  = 1'b1;
      pk_owner  = OWN_NONE;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk("stv_d_win", 64'(pk_win), 64'(OWN_D));
         step();
         chk("stv_cnt", 64'(u_pk.starve_cnt), 64'(i));
      end
      #1;
      chk("stv_if_forced", 64'(pk_win), 64'(OWN_IF));
      step();
      chk("stv_cnt_clr", 64'(u_pk.starve_cnt), 64'd0);
      #1;
      chk("stv_d_again", 64'(pk_win), 64'(OWN_D));
      pk_owner = OWN_D;
      #1;
      chk("stv_d_blocked", 64'(pk_win), 64'(OWN_IF));

      $display("Simulation finished: %0d checks, %0d errors",
               nchk, nerr);
      $finish;
   end

endmodule
